// File: rtl/usb_crc16_rx_chk.sv
// USB RX DATA-phase checker: CRC16 verify, CRC strip through a 2-byte hold line,
// payload buffered in a show-ahead FIFO with per-packet status pulses.
module usb_crc16_rx_chk #(
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_PKT_LEN = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_data_on,
  output logic       rx_sop_en,
  output logic       rx_lt_eop_en,
  input  logic       rx_sop,
  input  logic       rx_eop,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_lt_sop,
  output logic       rx_lt_eop,
  output logic       rx_lt_valid,
  input  logic       rx_lt_ready,
  output logic [7:0] rx_lt_data,
  output logic       rx_lt_err,
  output logic       crc_err,
  output logic       rx_zlp,
  output logic       len_err,
  output logic       proto_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(MAX_PKT_LEN + 2);
  localparam logic [LW-1:0] LMAX = LW'(MAX_PKT_LEN);
  localparam logic [LW-1:0] LSAT = LW'(MAX_PKT_LEN + 1);
  localparam logic [15:0]   RESIDUE = 16'hB001;

  typedef enum logic {IDLE, PKT} state_t;
  typedef struct packed {
    logic       sop;
    logic       eop;
    logic       err;
    logic [7:0] data;
  } ent_t;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  state_t        state, state_n;
  logic [15:0]   crc, crc_n, crc_b;
  logic [7:0]    h0, h1, h0_n, h1_n;
  logic [1:0]    hcnt, hcnt_n;
  logic          first, first_n;
  logic [LW-1:0] plen, plen_n, plen_inc;
  logic          crc_e_n, zlp_n, len_e_n, proto_n;

  ent_t          mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp;
  logic          full, empty, acc, push, pop;
  ent_t          push_ent, head;

  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rx_ready = rx_data_on & ~full;
  assign acc      = rx_valid & rx_ready;
  assign head     = mem[rp[AW-1:0]];
  assign pop      = rx_lt_valid & rx_lt_ready;

  assign rx_lt_valid  = ~empty;
  assign rx_lt_sop    = rx_lt_valid & head.sop;
  assign rx_lt_eop    = rx_lt_valid & head.eop;
  assign rx_lt_err    = rx_lt_valid & head.err;
  assign rx_lt_data   = rx_lt_valid ? head.data : 8'h00;
  assign rx_lt_eop_en = pop & head.eop & rx_data_on;
  assign rx_sop_en    = acc & rx_sop;

  always_comb begin
    state_n  = state;
    crc_n    = crc;
    h0_n     = h0;
    h1_n     = h1;
    hcnt_n   = hcnt;
    first_n  = first;
    plen_n   = plen;
    push     = 1'b0;
    push_ent = '0;
    crc_e_n  = 1'b0;
    zlp_n    = 1'b0;
    len_e_n  = 1'b0;
    proto_n  = 1'b0;
    crc_b    = crc_upd(crc, rx_data);
    plen_inc = (plen == LSAT) ? plen : plen + 1'b1;
    if (acc) begin
      if (rx_sop) begin
        // SOP always (re)starts a packet; any held bytes of an open packet are dropped
        proto_n = (state == PKT);
        crc_n   = crc_upd(16'hFFFF, rx_data);
        h0_n    = rx_data;
        hcnt_n  = 2'd1;
        first_n = 1'b1;
        plen_n  = '0;
        state_n = PKT;
        if (rx_eop) begin
          len_e_n = 1'b1;
          hcnt_n  = 2'd0;
          first_n = 1'b0;
          state_n = IDLE;
        end
      end else if (state == IDLE) begin
        proto_n = 1'b1;
      end else begin
        crc_n = crc_b;
        if (hcnt == 2'd2) begin
          push     = 1'b1;
          push_ent = '{sop: first, eop: rx_eop,
                       err: rx_eop & ((crc_b != RESIDUE) | (plen_inc > LMAX)),
                       data: h0};
          first_n  = 1'b0;
          plen_n   = plen_inc;
          h0_n     = h1;
          h1_n     = rx_data;
        end else begin
          h1_n   = rx_data;
          hcnt_n = 2'd2;
        end
        if (rx_eop) begin
          state_n = IDLE;
          hcnt_n  = 2'd0;
          crc_e_n = (crc_b != RESIDUE);
          zlp_n   = (hcnt != 2'd2);
          len_e_n = (hcnt == 2'd2) && (plen_inc > LMAX);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc       <= 16'hFFFF;
      h0        <= '0;
      h1        <= '0;
      hcnt      <= '0;
      first     <= 1'b0;
      plen      <= '0;
      wp        <= '0;
      rp        <= '0;
      crc_err   <= 1'b0;
      rx_zlp    <= 1'b0;
      len_err   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_n;
      crc       <= crc_n;
      h0        <= h0_n;
      h1        <= h1_n;
      hcnt      <= hcnt_n;
      first     <= first_n;
      plen      <= plen_n;
      crc_err   <= crc_e_n;
      rx_zlp    <= zlp_n;
      len_err   <= len_e_n;
      proto_err <= proto_n;
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= push_ent;

endmodule

// File: tb/tb_usb_crc16_rx_chk.sv
// Randomized bench for usb_crc16_rx_chk against a packet-level model of the
// input stream, the output FIFO contents and the status pulses.
module tb_usb_crc16_rx_chk;
  localparam int DEPTH = 16;
  localparam int MAXL  = 24;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic       r;
  } ent_t;

  logic       clk = 1'b0, rst_n = 1'b0, rx_data_on = 1'b0;
  logic       rx_sop = 1'b0, rx_eop = 1'b0, rx_valid = 1'b0, rx_lt_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_sop_en, rx_lt_eop_en, rx_ready, rx_lt_sop, rx_lt_eop, rx_lt_valid;
  logic       rx_lt_err, crc_err, rx_zlp, len_err, proto_err;
  logic [7:0] rx_lt_data;

  usb_crc16_rx_chk #(.FIFO_DEPTH(DEPTH), .MAX_PKT_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_on(rx_data_on), .rx_sop_en(rx_sop_en),
    .rx_lt_eop_en(rx_lt_eop_en), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_lt_sop(rx_lt_sop), .rx_lt_eop(rx_lt_eop),
    .rx_lt_valid(rx_lt_valid), .rx_lt_ready(rx_lt_ready), .rx_lt_data(rx_lt_data),
    .rx_lt_err(rx_lt_err), .crc_err(crc_err), .rx_zlp(rx_zlp), .len_err(len_err),
    .proto_err(proto_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int rdy_mode = 0;
  int zlp_seen = 0, crc_seen = 0, len_seen = 0, proto_seen = 0, eopen_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_q(input bq_t q);
    logic [15:0] c = 16'hFFFF;
    foreach (q[k])
      for (int i = 0; i < 8; i++)
        c = (c[0] ^ q[k][i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  // ---------------- behavioural model ----------------
  ent_t mq[$];
  ent_t outlog[$];
  bq_t  pkt;
  logic in_pkt = 1'b0;
  logic x_crc = 0, x_zlp = 0, x_len = 0, x_proto = 0;

  task automatic model_byte(input logic [7:0] d, input logic s, input logic e);
    int n;
    logic bad;
    if (s) begin
      if (in_pkt) x_proto = 1;
      pkt.delete();
      pkt.push_back(d);
      in_pkt = 1;
      if (e) begin x_len = 1; in_pkt = 0; end
    end else if (!in_pkt) begin
      x_proto = 1;
    end else begin
      pkt.push_back(d);
      n   = pkt.size();
      bad = e && (crc_q(pkt) != 16'hB001);
      // payload byte k leaves once byte k+2 arrives
      if (n >= 3) mq.push_back('{d: pkt[n-3], s: (n == 3), e: e, r: e && (bad || (n - 2) > MAXL)});
      if (e) begin
        in_pkt = 0;
        x_crc  = bad;
        x_zlp  = (n == 2);
        x_len  = (n >= 3) && ((n - 2) > MAXL);
      end
    end
  endtask

  always @(negedge clk) begin
    logic xr, acc, pop;
    if (!rst_n) begin
      chk("rst_ready", rx_ready, rx_data_on);
      chk("rst_outs", {rx_lt_valid, rx_lt_sop, rx_lt_eop, rx_lt_err, rx_lt_data,
                       crc_err, rx_zlp, len_err, proto_err, rx_sop_en, rx_lt_eop_en}, 0);
      mq.delete(); pkt.delete(); in_pkt = 0;
      x_crc = 0; x_zlp = 0; x_len = 0; x_proto = 0;
    end else begin
      xr = rx_data_on && (mq.size() < DEPTH);
      chk("rx_ready", rx_ready, xr);
      chk("lt_valid", rx_lt_valid, mq.size() > 0);
      if (mq.size() > 0)
        chk("lt_head", {rx_lt_data, rx_lt_sop, rx_lt_eop, rx_lt_err},
            {mq[0].d, mq[0].s, mq[0].e, mq[0].r});
      chk("pulses", {crc_err, rx_zlp, len_err, proto_err}, {x_crc, x_zlp, x_len, x_proto});
      zlp_seen += rx_zlp; crc_seen += crc_err; len_seen += len_err; proto_seen += proto_err;
      acc = rx_valid && xr;
      pop = (mq.size() > 0) && rx_lt_ready;
      chk("sop_en", rx_sop_en, acc && rx_sop);
      chk("eop_en", rx_lt_eop_en, pop && mq[0].e && rx_data_on);
      eopen_seen += rx_lt_eop_en;
      if (pop) outlog.push_back(mq.pop_front());
      x_crc = 0; x_zlp = 0; x_len = 0; x_proto = 0;
      if (acc) model_byte(rx_data, rx_sop, rx_eop);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       rx_lt_ready = 1'b1;
      1:       rx_lt_ready = 1'b0;
      default: rx_lt_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    logic a;
    int n = 0;
    rx_data = d; rx_sop = s; rx_eop = e; rx_valid = 1'b1;
    do begin @(negedge clk); a = rx_ready; @(posedge clk); #1; n++; end
    while (!a && n < 500);
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    if (!a) chk("send_timeout", 0, 1);
    if ($urandom_range(0, 3) == 0) idle(1);
  endtask

  task automatic send_raw(input bq_t b, input bit eop_last, input int pause_at);
    for (int i = 0; i < b.size(); i++) begin
      if (i == pause_at) begin rx_data_on = 1'b0; idle(5); rx_data_on = 1'b1; end
      send_byte(b[i], i == 0, eop_last && (i == b.size() - 1));
    end
  endtask

  task automatic send_pkt(input bq_t pl, input bit corrupt, input int pause_at);
    bq_t b;
    logic [15:0] c;
    b = pl;
    c = ~crc_q(pl);
    if (corrupt) c[0] = ~c[0];
    b.push_back(c[7:0]);
    b.push_back(c[15:8]);
    send_raw(b, 1, pause_at);
  endtask

  task automatic drain();
    int n = 0;
    while (mq.size() > 0 && n < 2000) begin idle(1); n++; end
    idle(2);
    chk("drained", rx_lt_valid, 0);
  endtask

  initial begin
    bq_t pl, e0, z2;
    int z0, c0, l0, p0, q0;
    rdy_mode = 0;
    rx_data_on = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // pin the reference CRC with hand-known values
    e0 = {};
    chk("crc_empty", crc_q(e0), 16'hFFFF);
    z2 = {8'h00, 8'h00};
    chk("residue_zlp", crc_q(z2), 16'hB001);
    z2 = {8'h00, 8'h01};
    chk("residue_bad", crc_q(z2) != 16'hB001, 1);

    // ZLP good and bad
    z0 = zlp_seen; c0 = crc_seen;
    z2 = {8'h00, 8'h00}; send_raw(z2, 1, -1); idle(2);
    chk("zlp_good", {zlp_seen - z0, crc_seen - c0}, {32'd1, 32'd0});
    z2 = {8'h00, 8'h01}; send_raw(z2, 1, -1); idle(2);
    chk("zlp_bad", {zlp_seen - z0, crc_seen - c0}, {32'd2, 32'd1});
    chk("zlp_nodata", outlog.size(), 0);

    // 01..08 good, then with a flipped CRC bit
    pl = {};
    for (int i = 1; i <= 8; i++) pl.push_back(8'(i));
    outlog.delete(); q0 = eopen_seen;
    send_pkt(pl, 0, -1); drain();
    chk("p8_count", outlog.size(), 8);
    chk("p8_first", {outlog[0].d, outlog[0].s}, {8'h01, 1'b1});
    chk("p8_last", {outlog[7].d, outlog[7].e, outlog[7].r}, {8'h08, 1'b1, 1'b0});
    chk("p8_eopen", eopen_seen - q0, 1);
    outlog.delete(); c0 = crc_seen;
    send_pkt(pl, 1, -1); drain();
    chk("p8_crcerr", crc_seen - c0, 1);
    chk("p8_lterr", {outlog.size(), outlog[7].r}, {32'd8, 1'b1});

    // backpressure with a 40-byte payload
    pl = {};
    for (int i = 0; i < 40; i++) pl.push_back(8'(i + 8'h40));
    rdy_mode = 1; outlog.delete();
    fork
      send_pkt(pl, 0, -1);
      begin
        idle(60);
        @(negedge clk);
        chk("bp_full", {rx_ready, rx_lt_valid}, {1'b0, 1'b1});
        @(posedge clk); #1;
        rdy_mode = 2;
      end
    join
    drain();
    chk("bp_count", outlog.size(), 40);
    for (int i = 0; i < 40 && i < outlog.size(); i++)
      chk("bp_order", outlog[i].d, 8'(i + 8'h40));

    // single byte sop+eop, then SOP inside a packet
    l0 = len_seen; p0 = proto_seen;
    z2 = {8'h5A}; send_raw(z2, 1, -1); idle(2);
    chk("len_single", len_seen - l0, 1);
    z2 = {8'h11, 8'h22, 8'h33, 8'h44}; send_raw(z2, 0, -1);
    pl = {8'hA1, 8'hA2, 8'hA3};
    outlog.delete(); c0 = crc_seen;
    send_pkt(pl, 0, -1); drain();
    chk("proto_sop", proto_seen - p0, 1);
    chk("proto_tail", {outlog[outlog.size()-1].d, outlog[outlog.size()-1].e,
                       outlog[outlog.size()-1].r, 32'(crc_seen - c0)}, {8'hA3, 1'b1, 1'b0, 32'd0});

    // length boundary: MAXL ok, MAXL+1 flagged
    l0 = len_seen;
    pl = {};
    for (int i = 0; i < MAXL; i++) pl.push_back(8'($urandom));
    send_pkt(pl, 0, -1); drain();
    chk("len_max_ok", len_seen - l0, 0);
    pl.push_back(8'h77); outlog.delete();
    send_pkt(pl, 0, -1); drain();
    chk("len_over", {32'(len_seen - l0), outlog.size(), outlog[MAXL].r}, {32'd1, 32'(MAXL + 1), 1'b1});

    // rx_data_on pause mid-packet
    pl = {};
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    c0 = crc_seen; outlog.delete();
    send_pkt(pl, 0, 4); drain();
    chk("pause_crc", {32'(crc_seen - c0), outlog.size()}, {32'd0, 32'd10});

    // reset mid-packet
    z2 = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; send_raw(z2, 0, -1);
    rst_n = 1'b0; idle(2); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_empty", {rx_lt_valid, rx_ready}, {1'b0, 1'b1});
    @(posedge clk); #1;
    c0 = crc_seen; outlog.delete();
    send_pkt(pl, 0, -1); drain();
    chk("rst_resume", {32'(crc_seen - c0), outlog.size()}, {32'd0, 32'd10});

    // random traffic
    rdy_mode = 2;
    for (int p = 0; p < 150; p++) begin
      int kind = $urandom_range(0, 9);
      int len  = $urandom_range(0, 30);
      pl = {};
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      if (kind == 0) send_byte(8'($urandom), 0, $urandom_range(0, 1));
      else if (kind == 1) send_raw(pl, 0, -1);
      else send_pkt(pl, (kind == 2), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : -1);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
